alarm_timekeeper: RTL
=====================

Name: alarm_timekeeper

Overview:
- Consumer of the seconds square wave produced by the seconds counter.
- Detects each rising edge of that wave as a one-second tick and maintains a binary 24-hour time of day.
- Compares the time against a programmable alarm and runs the ring/snooze state machine that drives the buzzer output.

Parameters:
- RING_SECS, 60, ticks the alarm rings before self-cancelling.
- SNOOZE_SECS, 300, ticks spent in snooze before ringing again.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, synchronous, active-low.
- sec_in  in  1  seconds square wave, synchronous to clk; each rising edge is one second.
- set_time  in  1  load-time strobe.
- set_hour  in  5  time hour to load, 0..23.
- set_min  in  6  time minute to load, 0..59.
- alarm_we  in  1  alarm-time write strobe.
- alarm_hour  in  5  alarm hour, 0..23.
- alarm_min  in  6  alarm minute, 0..59.
- alarm_en  in  1  alarm armed (level).
- snooze  in  1  snooze request (level, sampled each cycle).
- stop  in  1  stop request (level, sampled each cycle).
- hour  out  5  current hour.
- min  out  6  current minute.
- sec  out  6  current second.
- ring  out  1  buzzer drive.
- alarm_state  out  2  00 IDLE, 01 RINGING, 10 SNOOZED.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - hour/min/sec=0; alarm registers=0; FSM=IDLE; ring=0; internal counters=0.
  - sec_d is set to 1, so a sec_in held high through reset release produces no tick.
- Tick:
  - tick = sec_in & ~sec_d; sec_d <= sec_in every cycle.
  - All tick-driven updates happen at the same clk edge that first samples sec_in=1 after 0.
  - Exactly one tick per rising edge, regardless of high-time length.
- Time counting on tick:
  - sec 59->0 with min+1; min 59->0 with hour+1; hour 23->0 (full rollover 23:59:59 -> 00:00:00).
- set_time:
  - Loads hour=set_hour, min=set_min, sec=0 next edge; overrides a same-cycle tick, so that tick is lost.
  - Out-of-range values (hour>23 or min>59) are ignored entirely; time keeps running.
- alarm_we:
  - Loads alarm_hour/alarm_min; same range rule (whole write ignored if either field is invalid).
- Match:
  - Asserted only on a tick whose *next* time has sec==0 and hour:min equal to the alarm registers.
  - A set_time landing on the alarm time never matches.
- FSM (all transitions registered):
  - IDLE: match & alarm_en -> RINGING; ring_cnt=0.
  - RINGING:
    - ring=1.
    - stop -> IDLE.
    - Else snooze -> SNOOZED; snz_cnt=SNOOZE_SECS.
    - Else on tick ring_cnt+1; when ring_cnt reaches RING_SECS-1 on a tick -> IDLE (exactly RING_SECS ticks rung).
  - SNOOZED:
    - ring=0.
    - stop -> IDLE.
    - Else on tick snz_cnt-1; tick with snz_cnt==1 -> RINGING, ring_cnt=0.
    - snooze held in SNOOZED has no effect.
  - alarm_en=0 forces IDLE at the next edge from any state, with priority over all other events.
  - stop beats snooze when both are asserted together.
  - snooze/stop in IDLE are ignored.
  - A match while RINGING/SNOOZED is ignored.
- ring is a registered decode of state==RINGING and is never asserted in the same cycle as reset.
- Counter widths: $clog2(RING_SECS+1) and $clog2(SNOOZE_SECS+1); no wrap possible.

Test Plan:
- Reset with sec_in held high, release, hold sec_in high for 20 cycles -> no tick; time stays 00:00:00. Then 3 sec_in pulses -> sec=3.
- set_time 23:59, then 60 ticks -> on the 60th tick time=00:00:00. Also check 12:59:59 -> 13:00:00.
- set_time hour=24 min=10 -> ignored, time unchanged. set_time asserted coincident with a tick -> sec=0 and the tick is lost.
- Alarm 07:30, alarm_en=1, set_time 07:29, run 60 ticks -> RINGING and ring=1 at the edge where time becomes 07:30:00. With no input, ring drops after exactly RING_SECS=60 ticks (07:31:00), state IDLE.
- Ringing, assert snooze -> SNOOZED next edge, ring=0. After 300 ticks -> RINGING. Assert stop and snooze in the same cycle -> IDLE.
- Ringing, deassert alarm_en -> IDLE next edge. Assert rstn=0 while SNOOZED -> IDLE, time 00:00:00, alarm registers 0.

Source files
------------

// File: rtl/alarm_timekeeper_if.sv
// rtl/alarm_timekeeper_if.sv - time-set, alarm and buzzer signal bundle for alarm_timekeeper
interface alarm_timekeeper_if;
  logic       sec_in;
  logic       set_time;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic       alarm_we;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_en;
  logic       snooze;
  logic       stop;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       ring;
  logic [1:0] alarm_state;

  modport master (
    output sec_in, set_time, set_hour, set_min, alarm_we, alarm_hour, alarm_min,
           alarm_en, snooze, stop,
    input  hour, min, sec, ring, alarm_state
  );

  modport slave (
    input  sec_in, set_time, set_hour, set_min, alarm_we, alarm_hour, alarm_min,
           alarm_en, snooze, stop,
    output hour, min, sec, ring, alarm_state
  );
endinterface

// File: rtl/alarm_timekeeper.sv
// rtl/alarm_timekeeper.sv - 24h time of day from a seconds square wave, with alarm ring/snooze FSM
module alarm_timekeeper #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input logic                clk,
  input logic                rstn,
  alarm_timekeeper_if.slave  bus
);
  localparam int RW = $clog2(RING_SECS + 1);
  localparam int SW = $clog2(SNOOZE_SECS + 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
  localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_SECS);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RINGING = 2'b01,
    SNOOZED = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;
  logic          ring_q;
  logic          sec_d;
  logic [4:0]    hour_q, alarm_hour_q, nhour;
  logic [5:0]    min_q, sec_q, alarm_min_q, nmin, nsec;
  logic          tick, set_ok, alarm_ok, match;

  assign tick     = bus.sec_in & ~sec_d;
  assign set_ok   = bus.set_time & (bus.set_hour <= 5'd23) & (bus.set_min <= 6'd59);
  assign alarm_ok = bus.alarm_we & (bus.alarm_hour <= 5'd23) & (bus.alarm_min <= 6'd59);

  always_comb begin
    nsec  = sec_q + 6'd1;
    nmin  = min_q;
    nhour = hour_q;
    if (sec_q == 6'd59) begin
      nsec = 6'd0;
      if (min_q == 6'd59) begin
        nmin  = 6'd0;
        nhour = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
      end else begin
        nmin = min_q + 6'd1;
      end
    end
  end

  // A time load swallows the coincident tick, so it can never produce a match.
  assign match = tick & ~set_ok & (nsec == 6'd0) &
                 (nhour == alarm_hour_q) & (nmin == alarm_min_q);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sec_d        <= 1'b1;
      hour_q       <= 5'd0;
      min_q        <= 6'd0;
      sec_q        <= 6'd0;
      alarm_hour_q <= 5'd0;
      alarm_min_q  <= 6'd0;
    end else begin
      sec_d <= bus.sec_in;
      if (set_ok) begin
        hour_q <= bus.set_hour;
        min_q  <= bus.set_min;
        sec_q  <= 6'd0;
      end else if (tick) begin
        hour_q <= nhour;
        min_q  <= nmin;
        sec_q  <= nsec;
      end
      if (alarm_ok) begin
        alarm_hour_q <= bus.alarm_hour;
        alarm_min_q  <= bus.alarm_min;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      ring_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      ring_q     <= (state_d == RINGING);
    end
  end

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    if (!bus.alarm_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (match) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
          end
        end
        RINGING: begin
          if (bus.stop) begin
            state_d = IDLE;
          end else if (bus.snooze) begin
            state_d   = SNOOZED;
            snz_cnt_d = SNZ_LOAD;
          end else if (tick) begin
            if (ring_cnt_q == RING_LAST) state_d = IDLE;
            else ring_cnt_d = ring_cnt_q + RW'(1);
          end
        end
        SNOOZED: begin
          if (bus.stop) begin
            state_d = IDLE;
          end else if (tick) begin
            if (snz_cnt_q == SW'(1)) begin
              state_d    = RINGING;
              ring_cnt_d = '0;
            end else begin
              snz_cnt_d = snz_cnt_q - SW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.hour        = hour_q;
  assign bus.min         = min_q;
  assign bus.sec         = sec_q;
  assign bus.ring        = ring_q;
  assign bus.alarm_state = state_q;
endmodule
